// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The main register (M) always drives the decode side; the skid register (S)
// holds a second beat only while the stage is full. in_ready depends only on
// registered state (and reset), so there is no combinational path from the
// decode side or the hazard unit back into fetch. A saturating counter records
// how many valid beats each branch flush has squashed.
module ifid_skid_reg #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  // Occupancy doubles as the state of the buffer controller.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // All-ones value of the squash counter, widened to the sum width.
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  occ_e              occ_reg,        occ_next;
  logic [INST_W-1:0] m_inst_reg,     m_inst_next;
  logic [ADDR_W-1:0] m_pc_reg,       m_pc_next;
  logic [INST_W-1:0] s_inst_reg,     s_inst_next;
  logic [ADDR_W-1:0] s_pc_reg,       s_pc_next;
  logic [CNT_W-1:0]  squash_cnt_reg, squash_cnt_next;

  logic              push;
  logic              pop;
  logic [CNT_W+1:0]  squash_sum;

  // A stall looks exactly like the decode stage refusing the beat.
  assign in_ready  = (occ_reg != OCC_FULL) & reset;
  assign out_valid = (occ_reg != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~stall;

  // M is kept at zero whenever it is empty, so the bubble is already a NOP;
  // the gate below keeps the outputs zero even for the unused state encoding.
  assign out_inst   = out_valid ? m_inst_reg : '0;
  assign out_pc     = out_valid ? m_pc_reg   : '0;
  assign occupancy  = occ_reg;
  assign squash_cnt = squash_cnt_reg;

  // Beats dropped by a flush: everything held plus anything accepted that cycle.
  assign squash_sum = {2'b00, squash_cnt_reg}
                    + {{CNT_W{1'b0}}, occ_reg}
                    + {{(CNT_W+1){1'b0}}, push};

  // Next-state logic: buffer transitions, with flush overriding everything.
  always_comb begin
    occ_next        = occ_reg;
    m_inst_next     = m_inst_reg;
    m_pc_next       = m_pc_reg;
    s_inst_next     = s_inst_reg;
    s_pc_next       = s_pc_reg;
    squash_cnt_next = squash_cnt_reg;

    if (flush) begin
      occ_next        = OCC_EMPTY;
      m_inst_next     = '0;
      m_pc_next       = '0;
      s_inst_next     = '0;
      s_pc_next       = '0;
      squash_cnt_next = (squash_sum > CNT_MAX) ? {CNT_W{1'b1}}
                                               : squash_sum[CNT_W-1:0];
    end else begin
      case (occ_reg)
        OCC_EMPTY: begin
          if (push) begin
            m_inst_next = in_inst;
            m_pc_next   = in_pc;
            occ_next    = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            m_inst_next = in_inst;
            m_pc_next   = in_pc;
          end else if (push) begin
            // Decode is not taking M this cycle: park the new beat in S.
            s_inst_next = in_inst;
            s_pc_next   = in_pc;
            occ_next    = OCC_FULL;
          end else if (pop) begin
            m_inst_next = '0;
            m_pc_next   = '0;
            occ_next    = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            m_inst_next = s_inst_reg;
            m_pc_next   = s_pc_reg;
            s_inst_next = '0;
            s_pc_next   = '0;
            occ_next    = OCC_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          occ_next    = OCC_EMPTY;
          m_inst_next = '0;
          m_pc_next   = '0;
          s_inst_next = '0;
          s_pc_next   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_reg        <= OCC_EMPTY;
      m_inst_reg     <= '0;
      m_pc_reg       <= '0;
      s_inst_reg     <= '0;
      s_pc_reg       <= '0;
      squash_cnt_reg <= '0;
    end else begin
      occ_reg        <= occ_next;
      m_inst_reg     <= m_inst_next;
      m_pc_reg       <= m_pc_next;
      s_inst_reg     <= s_inst_next;
      s_pc_reg       <= s_pc_next;
      squash_cnt_reg <= squash_cnt_next;
    end
  end

endmodule
